// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between port 0 (CPU) and
// port 1 (loader/debug). Each transaction runs IDLE -> ACCESS (LAT cycles)
// -> DONE (one-cycle ack), with round-robin choice under contention.
//
// Handshake: a requester presents cmd (01 read, 10 write; 00/11 = none)
// with stable addr/wdata and holds them until its ack pulse. The request is
// latched at grant, so later input changes are ignored. If cmd is still
// valid in the IDLE cycle after the ack, it is a new request.
module mem_arbiter #(
  parameter int AW  = 9,
  parameter int DW  = 16,
  parameter int LAT = 1    // RAM access cycles per transaction, 1..15
) (
  input  logic          clk,
  input  logic          reset,     // asynchronous, active low
  input  logic [1:0]    cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [1:0]    cmd_q;        // latched command, kept through DONE
  logic [1:0]    mem_cmd_q;
  logic [AW-1:0] mem_addr_q;   // doubles as the latched address
  logic [DW-1:0] mem_wdata_q;  // doubles as the latched write data
  logic [DW-1:0] rdata_q;
  logic          gnt_q;
  logic          ack0_q;
  logic          ack1_q;

  logic          v0_d;
  logic          v1_d;
  logic          req_d;
  logic          win_d;
  logic [1:0]    cmd_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // Pick the winner among valid requests: the port not last granted wins a tie.
  always_comb begin
    v0_d  = (cmd0 == CMD_READ) || (cmd0 == CMD_WRITE);
    v1_d  = (cmd1 == CMD_READ) || (cmd1 == CMD_WRITE);
    req_d = v0_d || v1_d;
    if (v0_d && v1_d) begin
      win_d = ~gnt_q;
    end else begin
      win_d = v1_d;
    end
    cmd_d   = win_d ? cmd1   : cmd0;
    addr_d  = win_d ? addr1  : addr0;
    wdata_d = win_d ? wdata1 : wdata0;
  end

  // Transaction sequencer with registered RAM command, ack and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= CMD_NONE;
      mem_cmd_q   <= CMD_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      gnt_q       <= 1'b1;   // so port 0 wins the first contention
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_d) begin
            state_q     <= ACCESS;
            gnt_q       <= win_d;
            cmd_q       <= cmd_d;
            mem_cmd_q   <= cmd_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            cnt_q       <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (cmd_q == CMD_READ) begin
              rdata_q <= mem_rdata;
            end
            mem_cmd_q <= CMD_NONE;
            state_q   <= DONE;
            ack0_q    <= ~gnt_q;
            ack1_q    <= gnt_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign gnt       = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances with LAT = 1, 2, 3 share a clock
// and reset, each with its own behavioural RAM. Directed steps come first,
// then randomized requesters checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic [1:0]    cmd0      [N];
  logic [AW-1:0] addr0     [N];
  logic [DW-1:0] wdata0    [N];
  logic          ack0      [N];
  logic [1:0]    cmd1      [N];
  logic [AW-1:0] addr1     [N];
  logic [DW-1:0] wdata1    [N];
  logic          ack1      [N];
  logic [DW-1:0] rdata     [N];
  logic [1:0]    mem_cmd   [N];
  logic [AW-1:0] mem_addr  [N];
  logic [DW-1:0] mem_wdata [N];
  logic [DW-1:0] mem_rdata [N];
  logic          busy      [N];
  logic          gnt       [N];

  // bench RAM per instance, with a preload path
  logic [DW-1:0] ram       [N][512];
  logic          pl_en     [N];
  logic [AW-1:0] pl_addr   [N];
  logic [DW-1:0] pl_data   [N];

  logic [DW-1:0] model_mem [N][16];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and RAMs ----------------
  for (genvar k = 0; k < N; k++) begin : g_dut
    mem_arbiter #(.AW(AW), .DW(DW), .LAT(k + 1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cmd0      (cmd0[k]),
      .addr0     (addr0[k]),
      .wdata0    (wdata0[k]),
      .ack0      (ack0[k]),
      .cmd1      (cmd1[k]),
      .addr1     (addr1[k]),
      .wdata1    (wdata1[k]),
      .ack1      (ack1[k]),
      .rdata     (rdata[k]),
      .mem_cmd   (mem_cmd[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_rdata (mem_rdata[k]),
      .busy      (busy[k]),
      .gnt       (gnt[k])
    );
    assign mem_rdata[k] = (mem_cmd[k] == 2'b01) ? ram[k][mem_addr[k]] : '0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (pl_en[k]) ram[k][pl_addr[k]] <= pl_data[k];
      else if (mem_cmd[k] == 2'b10) ram[k][mem_addr[k]] <= mem_wdata[k];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input int p, input logic [1:0] c,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      cmd0[k] = c; addr0[k] = a; wdata0[k] = d;
    end else begin
      cmd1[k] = c; addr1[k] = a; wdata1[k] = d;
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      drive(k, 0, 2'b00, '0, '0);
      drive(k, 1, 2'b00, '0, '0);
      pl_en[k] = 1'b0; pl_addr[k] = '0; pl_data[k] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // One isolated transaction on instance k, port p; addr input switches to
  // chg after the first ACCESS cycle to show the latched request is used.
  task automatic xfer(input int k, input int p, input logic [1:0] c,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_rd, input logic [AW-1:0] chg,
                      input string tag);
    drive(k, p, c, a, d);
    tick();
    for (int i = 0; i < k + 1; i++) begin
      check({tag, "_acc_cmd"},  32'(mem_cmd[k]),   32'(c));
      check({tag, "_acc_addr"}, 32'(mem_addr[k]),  32'(a));
      check({tag, "_acc_wd"},   32'(mem_wdata[k]), 32'(d));
      check({tag, "_acc_busy"}, 32'(busy[k]), 32'd1);
      check({tag, "_acc_ack"},  32'(ack0[k] | ack1[k]), 32'd0);
      if (i == 0) drive(k, p, c, chg, d);
      tick();
    end
    check({tag, "_ack0"},  32'(ack0[k]), 32'(p == 0));
    check({tag, "_ack1"},  32'(ack1[k]), 32'(p == 1));
    check({tag, "_rdata"}, 32'(rdata[k]), 32'(exp_rd));
    check({tag, "_dcmd"},  32'(mem_cmd[k]), 32'd0);
    check({tag, "_gnt"},   32'(gnt[k]), 32'(p));
    drive(k, p, 2'b00, '0, '0);
    tick();
    check({tag, "_idle"},  32'(busy[k]), 32'd0);
    check({tag, "_noack"}, 32'(ack0[k] | ack1[k]), 32'd0);
  endtask

  // ---------------- random-phase model state ----------------
  int            m_g     [N];
  int            m_free  [N];
  logic          m_has   [N];
  logic          m_gnt   [N];
  logic          m_port  [N];
  logic [1:0]    m_cmd   [N];
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_wdata [N];
  logic [DW-1:0] m_rdata [N];
  logic          req_on    [N][2];
  logic [1:0]    req_cmd   [N][2];
  logic [AW-1:0] req_addr  [N][2];
  logic [DW-1:0] req_wdata [N][2];

  task automatic new_req(input int k, input int p);
    req_on[k][p]    = 1'b1;
    req_cmd[k][p]   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    req_addr[k][p]  = AW'($urandom_range(0, 15));
    req_wdata[k][p] = DW'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e;
    logic inacc, done, w;
    clear_all();
    reset = 1'b0;

    // preload RAM while reset is held; low byte encodes instance/address
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < N; k++) begin
        model_mem[k][a] = {8'($urandom), 4'(k), 4'(a)};
        pl_en[k] = 1'b1; pl_addr[k] = AW'(a); pl_data[k] = model_mem[k][a];
      end
      tick();
    end
    pl_en[0] = 1'b1; pl_addr[0] = 9'h010; pl_data[0] = 16'hBEEF;
    tick();
    clear_all();

    // reset values
    for (int k = 0; k < N; k++) begin
      check("rst_ack0",  32'(ack0[k]), 32'd0);
      check("rst_ack1",  32'(ack1[k]), 32'd0);
      check("rst_busy",  32'(busy[k]), 32'd0);
      check("rst_gnt",   32'(gnt[k]), 32'd1);
      check("rst_mcmd",  32'(mem_cmd[k]), 32'd0);
      check("rst_maddr", 32'(mem_addr[k]), 32'd0);
      check("rst_mwd",   32'(mem_wdata[k]), 32'd0);
      check("rst_rdata", 32'(rdata[k]), 32'd0);
    end
    reset = 1'b1;
    tick();

    // reset during the 2nd ACCESS cycle, LAT=3
    drive(2, 0, 2'b01, 9'h005, '0);
    tick();
    check("mid_acc1_cmd", 32'(mem_cmd[2]), 32'd1);
    check("mid_acc1_busy", 32'(busy[2]), 32'd1);
    tick();
    check("mid_acc2_cmd", 32'(mem_cmd[2]), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_cmd",  32'(mem_cmd[2]), 32'd0);
    check("mid_rst_busy", 32'(busy[2]), 32'd0);
    check("mid_rst_ack",  32'(ack0[2]), 32'd0);
    check("mid_rst_addr", 32'(mem_addr[2]), 32'd0);
    drive(2, 0, 2'b00, '0, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mid_hold_ack", 32'(ack0[2]), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_busy", 32'(busy[2]), 32'd0);
      check("post_rst_cmd",  32'(mem_cmd[2]), 32'd0);
      check("post_rst_ack",  32'(ack0[2] | ack1[2]), 32'd0);
    end

    // single read LAT=1, then read + write LAT=2
    xfer(0, 0, 2'b01, 9'h010, '0, 16'hBEEF, 9'h010, "rd_lat1");
    xfer(1, 1, 2'b01, 9'h006, '0, model_mem[1][6], 9'h006, "pre_rd");
    xfer(1, 1, 2'b10, 9'h0FF, 16'h1234, model_mem[1][6], 9'h0FF, "wr_lat2");
    check("wr_ram", 32'(ram[1][9'h0FF]), 32'h1234);

    // contention from reset, LAT=1: grants alternate 0,1,0,1
    do_reset();
    drive(0, 0, 2'b01, 9'h001, '0);
    drive(0, 1, 2'b01, 9'h002, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_gnt",  32'(gnt[0]), 32'(i % 2));
      check("cont_addr", 32'(mem_addr[0]), (i % 2 == 1) ? 32'h2 : 32'h1);
      check("cont_cmd",  32'(mem_cmd[0]), 32'd1);
      tick();
      check("cont_ack0", 32'(ack0[0]), 32'(i % 2 == 0));
      check("cont_ack1", 32'(ack1[0]), 32'(i % 2 == 1));
      check("cont_rd",   32'(rdata[0]), 32'(model_mem[0][(i % 2 == 1) ? 2 : 1]));
      tick();
      check("cont_idle", 32'(busy[0]), 32'd0);
    end
    clear_all();
    tick();

    // illegal command 11 alone, then alongside a port 1 read
    drive(0, 0, 2'b11, 9'h00A, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ill_busy", 32'(busy[0]), 32'd0);
      check("ill_cmd",  32'(mem_cmd[0]), 32'd0);
    end
    xfer(0, 1, 2'b01, 9'h007, '0, model_mem[0][7], 9'h007, "ill_p1");
    clear_all();

    // address changes after grant, LAT=3
    xfer(2, 0, 2'b01, 9'h003, '0, model_mem[2][3], 9'h004, "chg");

    // randomized requesters vs transaction model
    clear_all();
    do_reset();
    e = 0;
    for (int k = 0; k < N; k++) begin
      m_has[k] = 1'b0; m_free[k] = 0; m_g[k] = 0; m_gnt[k] = 1'b1;
      m_rdata[k] = '0; m_port[k] = 1'b0; m_cmd[k] = 2'b00;
      m_addr[k] = '0; m_wdata[k] = '0;
      for (int p = 0; p < 2; p++) begin
        req_on[k][p] = 1'b0; req_cmd[k][p] = 2'b00;
        req_addr[k][p] = '0; req_wdata[k][p] = '0;
      end
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < N; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (req_on[k][p]) drive(k, p, req_cmd[k][p], req_addr[k][p], req_wdata[k][p]);
          else drive(k, p, ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00,
                     AW'($urandom_range(0, 511)), DW'($urandom));
        end
        if (e + 1 >= m_free[k] && (req_on[k][0] || req_on[k][1])) begin
          w = (req_on[k][0] && req_on[k][1]) ? !m_gnt[k] : req_on[k][1];
          m_gnt[k] = w; m_port[k] = w; m_has[k] = 1'b1;
          m_g[k] = e + 1; m_free[k] = e + 1 + (k + 1) + 2;
          m_cmd[k] = req_cmd[k][w]; m_addr[k] = req_addr[k][w]; m_wdata[k] = req_wdata[k][w];
          if (m_cmd[k] == 2'b10) model_mem[k][m_addr[k][3:0]] = m_wdata[k];
        end
      end
      tick();
      e++;
      for (int k = 0; k < N; k++) begin
        inacc = m_has[k] && (e >= m_g[k]) && (e < m_g[k] + k + 1);
        done  = m_has[k] && (e == m_g[k] + k + 1);
        if (done && m_cmd[k] == 2'b01) m_rdata[k] = model_mem[k][m_addr[k][3:0]];
        check("rnd_busy", 32'(busy[k]), 32'(inacc || done));
        check("rnd_mcmd", 32'(mem_cmd[k]), inacc ? 32'(m_cmd[k]) : 32'd0);
        check("rnd_ack0", 32'(ack0[k]), 32'(done && !m_port[k]));
        check("rnd_ack1", 32'(ack1[k]), 32'(done && m_port[k]));
        check("rnd_gnt",  32'(gnt[k]), 32'(m_gnt[k]));
        check("rnd_rdata", 32'(rdata[k]), 32'(m_rdata[k]));
        if (inacc) begin
          check("rnd_maddr", 32'(mem_addr[k]), 32'(m_addr[k]));
          check("rnd_mwd",   32'(mem_wdata[k]), 32'(m_wdata[k]));
        end
        for (int p = 0; p < 2; p++) begin
          if (req_on[k][p] && done && (int'(m_port[k]) == p)) begin
            if ($urandom_range(0, 1) == 1) new_req(k, p);
            else req_on[k][p] = 1'b0;
          end else if (!req_on[k][p] && $urandom_range(0, 2) == 0) begin
            new_req(k, p);
          end
        end
      end
    end
    clear_all();
    for (int i = 0; i < 6; i++) tick();
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < 16; a++) begin
        check("rnd_ram", 32'(ram[k][a]), 32'(model_mem[k][a]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
